// File: rtl/cordic_vec_pkg.sv
// rtl/cordic_vec_pkg.sv - shared CORDIC vectoring types, constants and atan table (CORDIC_GAIN_COMP_EN)
package cordic_vec_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_SCALE,
    S_DONE
  } state_t;

  localparam int IDX_W      = 5;
  localparam int GUARD_BITS = 4;

`ifdef CORDIC_GAIN_COMP_EN
  localparam int INV_K_Q18  = 159188;
  localparam int INV_K_FRAC = 18;
`endif

  function automatic int quarter_turn(input int w);
    return 1 << (w - 2);
  endfunction

  // round(atan(2^-i) * 2^18 / (2*pi)); a full turn is 2^18 at W=18
  function automatic int atan_w18(input int i);
    case (i)
      0:       return 32768;
      1:       return 19344;
      2:       return 10221;
      3:       return 5188;
      4:       return 2604;
      5:       return 1303;
      6:       return 652;
      7:       return 326;
      8:       return 163;
      9:       return 81;
      10:      return 41;
      11:      return 20;
      12:      return 10;
      13:      return 5;
      14:      return 3;
      15:      return 1;
      16:      return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int atan_lsb(input int w, input int i);
    int t = atan_w18(i);
    if (w >= 18) return t << (w - 18);
    return (t + (1 << (17 - w))) >>> (18 - w);
  endfunction

endpackage

// File: rtl/cordic_vec_if.sv
// rtl/cordic_vec_if.sv - start/done request and result bundle of the vectoring engine
interface cordic_vec_if #(
  parameter int W = 18
);
  logic                start;
  logic signed [W-1:0] x0;
  logic signed [W-1:0] y0;
  logic                busy;
  logic                done;
  logic signed [W+1:0] mag;
  logic signed [W-1:0] zn;

  modport master (output start, x0, y0, input busy, done, mag, zn);
  modport slave  (input start, x0, y0, output busy, done, mag, zn);
endinterface

// File: rtl/cordic_atan_rom.sv
// rtl/cordic_atan_rom.sv - combinational micro-rotation angle lookup, i -> atan_i in W-bit turn units
module cordic_atan_rom
  import cordic_vec_pkg::*;
#(
  parameter int W = 18
) (
  input  logic [IDX_W-1:0]    idx,
  output logic signed [W-1:0] atan
);

  always_comb begin
    atan = W'(atan_lsb(W, int'(idx)));
  end

endmodule

// File: rtl/cordic_vec.sv
// rtl/cordic_vec.sv - iterative vectoring CORDIC, (x0,y0) -> magnitude and atan2 phase
// CORDIC_GAIN_COMP_EN adds a SCALE state that removes the CORDIC gain from mag.
module cordic_vec
  import cordic_vec_pkg::*;
#(
  parameter int W = 18,
  parameter int N = 16
) (
  input  logic        clk,
  input  logic        rst,
  cordic_vec_if.slave bus
);

  localparam int G  = GUARD_BITS;
  localparam int MW = W + 2;
  localparam int DW = MW + G;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic signed [W-1:0] ANG_P90 = W'(quarter_turn(W));

  state_t               state;
  logic signed [DW-1:0] x, y, x_n, y_n, x0_s, y0_s, x_rnd;
  logic signed [W-1:0]  z, z_n, atan_i;
  logic signed [MW-1:0] x_mag;
  logic [CW-1:0]        cnt;
  logic                 zero_in;
  logic                 busy_r, done_r;
  logic signed [MW-1:0] mag_r;
  logic signed [W-1:0]  zn_r;

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.mag  = mag_r;
  assign bus.zn   = zn_r;

  // Fractional guard bits keep truncation of the shifted terms from biasing mag and phase
  assign x0_s = {{2{bus.x0[W-1]}}, bus.x0, {G{1'b0}}};
  assign y0_s = {{2{bus.y0[W-1]}}, bus.y0, {G{1'b0}}};

  cordic_atan_rom #(.W(W)) u_atan_rom (
    .idx  (IDX_W'(cnt)),
    .atan (atan_i)
  );

  always_comb begin
    if (!y[DW-1]) begin
      x_n = x + (y >>> cnt);
      y_n = y - (x >>> cnt);
      z_n = z + atan_i;
    end else begin
      x_n = x - (y >>> cnt);
      y_n = y + (x >>> cnt);
      z_n = z - atan_i;
    end
  end

  assign x_rnd = x_n + (DW'(1) <<< (G - 1));
  assign x_mag = MW'(x_rnd >>> G);

`ifdef CORDIC_GAIN_COMP_EN
  localparam int PW = DW + 19;
  logic signed [PW-1:0] prod, prod_r;
  logic signed [MW-1:0] x_scaled;

  assign prod     = PW'(x) * PW'(INV_K_Q18);
  assign prod_r   = prod + (PW'(1) <<< (INV_K_FRAC + G - 1));
  assign x_scaled = MW'(prod_r >>> (INV_K_FRAC + G));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      cnt     <= '0;
      zero_in <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      mag_r   <= '0;
      zn_r    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        // DONE accepts a new start exactly like IDLE
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (bus.start) begin
            if (!bus.x0[W-1]) begin
              x <= x0_s;
              y <= y0_s;
              z <= '0;
            end else if (!bus.y0[W-1]) begin
              x <= y0_s;
              y <= -x0_s;
              z <= ANG_P90;
            end else begin
              x <= -y0_s;
              y <= x0_s;
              z <= -ANG_P90;
            end
            zero_in <= (bus.x0 == '0) && (bus.y0 == '0);
            cnt     <= '0;
            busy_r  <= 1'b1;
            state   <= S_ITER;
          end
        end
        S_ITER: begin
          x   <= x_n;
          y   <= y_n;
          z   <= z_n;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
            state <= S_SCALE;
`else
            mag_r  <= x_mag;
            zn_r   <= zero_in ? '0 : z_n;
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= S_DONE;
`endif
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        S_SCALE: begin
          mag_r  <= x_scaled;
          zn_r   <= zero_in ? '0 : z;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= S_DONE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
